// File: rtl/bitwise_acc_unit.sv
// rtl/bitwise_acc_unit.sv - bitwise accumulator with multi-cycle chunked OR-reduce
// One command in flight; non-reduce ops finish on the accept edge, reduce walks acc in CHUNK slices.
module bitwise_acc_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH <= 0 || CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("bitwise_acc_unit: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_NOT    = 3'b101;
  localparam logic [2:0] OP_REDUCE = 3'b110;
  localparam logic [2:0] OP_CLEAR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             por_q, por_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu;
  logic [CHUNK-1:0] chunk_sel;
  logic             chunk_or;
  logic             last_chunk;

  always_comb begin
    alu = acc_q;
    unique case (op)
      OP_NOP:    alu = acc_q;
      OP_LOAD:   alu = operand;
      OP_AND:    alu = acc_q & operand;
      OP_OR:     alu = acc_q | operand;
      OP_XOR:    alu = acc_q ^ operand;
      OP_NOT:    alu = ~acc_q;
      OP_REDUCE: alu = acc_q;
      OP_CLEAR:  alu = '0;
      default:   alu = acc_q;
    endcase
  end

  // Explicit mux avoids a variable-width multiply in the slice index.
  always_comb begin
    chunk_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        chunk_sel = acc_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign chunk_or   = |chunk_sel;
  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    por_d    = por_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_REDUCE) begin
            por_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_REDUCE;
          end else begin
            acc_d    = alu;
            result_d = alu;
            state_d  = S_HOLD;
          end
        end
      end
      S_REDUCE: begin
        por_d = por_q | chunk_or;
        if (last_chunk) begin
          result_d    = '0;
          result_d[0] = por_q | chunk_or;
          cnt_d       = '0;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      por_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      por_q    <= por_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign zero      = (acc_q == '0);

endmodule
